// File: rtl/counter_pkg.sv
// Shared types and helpers for the BCD counter family.
// Holds the FSM state type, digit limits and the load-value digit saturator.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } counterState;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter: loadable, decrements on dec, 0 wraps to 9.
module bcd_digit_down
  import counter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       dec,
  output logic [3:0] q,
  output logic       is_zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= BCD_ZERO;
    end else if (load) begin
      q <= ld_val;
    end else if (dec) begin
      q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
    end
  end

  assign is_zero = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD countdown timer with done pulse and optional auto-reload.
// Top holds the FSM, the reload register and the registered done pulse.
module bcd_down_counter
  import counter_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] dout,
  output logic                zero,
  output logic                busy,
  output logic                done,
  output logic                bout
);

  localparam int W = 4 * DIGITS;

  counterState         state;
  logic [W-1:0]        sanDin;
  logic [W-1:0]        reloadReg;
  logic [W-1:0]        ldVal;
  logic [DIGITS-1:0]   isZero;
  logic [DIGITS-1:0]   digitDec;
  logic                stepEn;
  logic                countStep;
  logic                reloadNow;
  logic                digitLoad;
  logic                atOne;
  logic                lowZero;

  always_comb begin
    sanDin = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      sanDin[4*k +: 4] = bcd_sat(din[4*k +: 4]);
    end
  end

  assign zero      = &isZero;
  assign atOne     = (dout == W'(1));
  assign busy      = (state == RUN);
  assign stepEn    = busy & enable & ~load;
  assign countStep = stepEn & ~zero;
  // RUN at zero only occurs with auto-reload; the reload replaces the decrement.
  assign reloadNow = AUTO_RELOAD & stepEn & zero;
  assign bout      = reloadNow;
  assign digitLoad = load | reloadNow;
  assign ldVal     = load ? sanDin : reloadReg;

  // A digit steps only when every lower digit is already zero (borrow ripple).
  always_comb begin
    lowZero  = 1'b1;
    digitDec = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      digitDec[k] = countStep & lowZero;
      lowZero     = lowZero & isZero[k];
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : gDigit
    bcd_digit_down uDigit (
      .clock   (clock),
      .reset   (reset),
      .load    (digitLoad),
      .ld_val  (ldVal[4*k +: 4]),
      .dec     (digitDec[k]),
      .q       (dout[4*k +: 4]),
      .is_zero (isZero[k])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      reloadReg <= '0;
      done      <= 1'b0;
    end else begin
      done <= countStep & atOne;
      if (load) begin
        reloadReg <= sanDin;
        state     <= (sanDin != '0) ? RUN : IDLE;
      end else if (countStep && atOne && !AUTO_RELOAD) begin
        state <= DONE;
      end
    end
  end

endmodule
